// File: rtl/trap_pkg.sv
// Shared types and encodings for the machine-mode trap controller.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRAP_SAVE = 2'd1,
    TRAP_JUMP = 2'd2,
    RET_JUMP  = 2'd3
  } state_e;

  typedef enum logic {
    CSR_RW = 1'b0,
    CSR_RS = 1'b1
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] ECALL_INSN     = 32'h0000_0073;
  localparam logic [31:0] MRET_INSN      = 32'h3020_0073;
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_CSRRW   = 3'b001;
  localparam logic [2:0] F3_CSRRS   = 3'b010;

  function automatic logic [31:0] csr_new(input csr_op_e op, input logic [31:0] old_val,
                                          input logic [31:0] wdata);
    return (op == CSR_RS) ? (old_val | wdata) : wdata;
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// mstatus/mtvec/mepc/mcause storage with read mux; CSR writes land on the accept edge,
// trap entry/return side effects are applied by strobes from the controller FSM.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          csr_en_i,
  input  csr_op_e       csr_op_i,
  input  logic [11:0]   csr_addr_i,
  input  logic [31:0]   csr_wdata_i,
  input  logic          trap_save_i,
  input  logic [31:0]   trap_pc_i,
  input  logic          trap_ret_i,
  output logic [31:0]   csr_rdata_o,
  output logic [31:0]   mtvec_o,
  output logic [31:0]   mepc_o
);

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] new_val;

  always_comb begin
    case (csr_addr_i)
      CSR_MSTATUS: csr_rdata_o = mstatus_q;
      CSR_MTVEC:   csr_rdata_o = mtvec_q;
      CSR_MEPC:    csr_rdata_o = mepc_q;
      CSR_MCAUSE:  csr_rdata_o = mcause_q;
      default:     csr_rdata_o = 32'h0;
    endcase
  end

  assign new_val = csr_new(csr_op_i, csr_rdata_o, csr_wdata_i);

  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (csr_en_i) begin
      case (csr_addr_i)
        CSR_MSTATUS: mstatus_d = new_val;
        CSR_MTVEC:   mtvec_d   = new_val;
        CSR_MEPC:    mepc_d    = {new_val[31:2], 2'b00};
        CSR_MCAUSE:  mcause_d  = new_val;
        default:     ;
      endcase
    end
    // Strobes only fire outside IDLE, so they never coincide with a CSR write.
    if (trap_save_i) begin
      mepc_d            = {trap_pc_i[31:2], 2'b00};
      mcause_d          = MCAUSE_ECALL_M;
      mstatus_d[7]      = mstatus_q[3];
      mstatus_d[3]      = 1'b0;
      mstatus_d[12:11]  = 2'b11;
    end
    if (trap_ret_i) begin
      mstatus_d[3]      = mstatus_q[7];
      mstatus_d[7]      = 1'b1;
      mstatus_d[12:11]  = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q <= MSTATUS_RESET;
      mtvec_q   <= MTVEC_RESET;
      mepc_q    <= 32'h0;
      mcause_q  <= 32'h0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode ecall/mret sequencer with zero-latency csrrw/csrrs access.
// Accepts only in IDLE; ecall redirects two cycles after accept, mret one cycle after.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ist_valid,
  input  logic [31:0] ist,
  input  logic [31:0] pc,
  output logic        ist_ready,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        ecall_evt,
  output logic        mret_evt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        is_csr;
  logic        csr_en;
  logic        trap_save;
  logic        trap_ret;
  logic [31:0] csr_rd;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  csr_op_e     csr_op;

  assign is_csr = (ist[6:0] == OPC_SYSTEM) &&
                  ((ist[14:12] == F3_CSRRW) || (ist[14:12] == F3_CSRRS));
  assign csr_op = (ist[14:12] == F3_CSRRS) ? CSR_RS : CSR_RW;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ist_ready      = 1'b0;
    csr_en         = 1'b0;
    csr_rdata      = 32'h0;
    trap_save      = 1'b0;
    trap_ret       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ecall_evt      = 1'b0;
    mret_evt       = 1'b0;
    case (state_q)
      IDLE: begin
        ist_ready = 1'b1;
        if (ist_valid) begin
          if (ist == ECALL_INSN) begin
            pc_d    = pc;
            state_d = TRAP_SAVE;
          end else if (ist == MRET_INSN) begin
            state_d = RET_JUMP;
          end else if (is_csr) begin
            csr_en    = 1'b1;
            csr_rdata = csr_rd;
          end
        end
      end
      TRAP_SAVE: begin
        trap_save = 1'b1;
        ecall_evt = 1'b1;
        state_d   = TRAP_JUMP;
      end
      TRAP_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = mtvec & ~32'h3;
        state_d        = IDLE;
      end
      RET_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = mepc;
        mret_evt       = 1'b1;
        trap_ret       = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  trap_csr_file #(
    .MTVEC_RESET   (MTVEC_RESET),
    .MSTATUS_RESET (MSTATUS_RESET)
  ) u_csr (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_en_i    (csr_en),
    .csr_op_i    (csr_op),
    .csr_addr_i  (ist[31:20]),
    .csr_wdata_i (csr_wdata),
    .trap_save_i (trap_save),
    .trap_pc_i   (pc_q),
    .trap_ret_i  (trap_ret),
    .csr_rdata_o (csr_rd),
    .mtvec_o     (mtvec),
    .mepc_o      (mepc)
  );

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec.
REQ-002 SHALL have parameter MSTATUS_RESET, default 32'h0000_1800, reset value of mstatus (MPP=11).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ist_valid  input  1  instruction presented this cycle.
REQ-006 SHALL have port ist  input  32  instruction word.
REQ-007 SHALL have port pc  input  32  address of ist.
REQ-008 SHALL have port ist_ready  output  1  block can accept; accept = ist_valid & ist_ready.
REQ-009 SHALL have port csr_wdata  input  32  rs1 operand for CSR ops.
REQ-010 SHALL have port csr_rdata  output  32  old CSR value for rd, valid in the accept cycle.
REQ-011 SHALL have port redirect_valid  output  1  one-cycle PC redirect strobe.
REQ-012 SHALL have port redirect_pc  output  32  redirect target, meaningful only with redirect_valid.
REQ-013 SHALL have ports ecall_evt and mret_evt  output  1 each  one-cycle event pulses for the simulation DPI hook.

Function
REQ-014 SHALL decode ecall as ist==32'h0000_0073 and mret as ist==32'h3020_0073.
REQ-015 SHALL decode CSR ops as ist[6:0]==7'b1110011 with funct3 001 (csrrw) or 010 (csrrs); address ist[31:20].
REQ-016 SHALL implement mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342; other addresses read 0, writes ignored.
REQ-017 SHALL use FSM states IDLE, TRAP_SAVE, TRAP_JUMP, RET_JUMP; ist_ready=1 only in IDLE.
REQ-018 SHALL, on accepted CSR op in IDLE, drive csr_rdata combinationally with the old value and write at the same edge: csrrw new=csr_wdata, csrrs new=old|csr_wdata; state stays IDLE (zero latency).
REQ-019 SHALL force mepc[1:0]=0 on every mepc write.
REQ-020 SHALL drive csr_rdata=0 whenever no CSR op is accepted.
REQ-021 SHALL, on accepted ecall, capture pc and go IDLE->TRAP_SAVE.
REQ-022 SHALL, in TRAP_SAVE: mepc<=captured pc&~3, mcause<=32'd11, mstatus.MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=2'b11, ecall_evt=1; next TRAP_JUMP.
REQ-023 SHALL, in TRAP_JUMP: redirect_valid=1, redirect_pc=mtvec&~32'h3; next IDLE (ecall: accept + 2 cycles, redirect on cycle 3).
REQ-024 SHALL, on accepted mret, go IDLE->RET_JUMP.
REQ-025 SHALL, in RET_JUMP: redirect_valid=1, redirect_pc=mepc, mret_evt=1, mstatus.MIE<=MPIE, MPIE<=1, MPP<=2'b11; next IDLE.
REQ-026 SHALL treat any other accepted instruction as a no-op; ist_valid low in IDLE holds state.
REQ-027 SHALL keep redirect_valid, ecall_evt, mret_evt low in all states not named above.
REQ-028 SHALL ignore ist/ist_valid while not in IDLE (no accept, no CSR effect).

Reset
REQ-029 SHALL, on rst_n low, immediately (asynchronously) enter IDLE and set mstatus=MSTATUS_RESET, mtvec=MTVEC_RESET, mepc=0, mcause=0, captured pc=0.
REQ-030 SHALL hold outputs at reset: ist_ready=1, redirect_valid=0, redirect_pc=0, ecall_evt=0, mret_evt=0, csr_rdata=0 (if ist_valid=0).
REQ-031 SHALL abort any in-flight trap/return on reset with no redirect emitted.

Structure
REQ-032 SHALL place the state enum, CSR address constants, ECALL/MRET encodings and MCAUSE_ECALL_M=11 in shared package trap_pkg.
REQ-033 SHALL implement the four CSRs and read mux in sub-module trap_csr_file; FSM stays in trap_ctrl.

Verification
REQ-034 SHALL test csrrw 0x305 with csr_wdata=32'h8000_0103 -> csr_rdata=MTVEC_RESET same cycle; next read of 0x305 returns 32'h8000_0103.
REQ-035 SHALL test ecall at pc=32'h8000_0040 with mtvec=32'h8000_0103 -> ist_ready low 2 cycles, ecall_evt in cycle 2, redirect_valid with redirect_pc=32'h8000_0100 in cycle 3, mepc=32'h8000_0040, mcause=11.
REQ-036 SHALL test mret after REQ-035 with mstatus.MPIE=1 -> redirect_pc=32'h8000_0040 next cycle, mret_evt=1, MIE=1, MPIE=1.
REQ-037 SHALL test csrrs 0x300 with csr_wdata=32'h8 from MSTATUS_RESET -> csr_rdata=32'h1800, mstatus=32'h1808; csr access to 0x7C0 -> reads 0, no write.
REQ-038 SHALL test rst_n asserted during TRAP_SAVE -> state IDLE, no redirect_valid, mepc=0, ist_ready=1 immediately.
